// File: rtl/plot_pixel_sink.sv
// Pixel-plot sink: queues plot requests in a small FIFO and writes them,
// or full-screen clears, into a 160x120x3 frame memory over a ready/valid port.
//
// Ports:
//   CLOCK_50, reset             : clock, asynchronous active-high reset
//   x, y, colour, plot          : pixel plot request (one-cycle strobe)
//   clear, clear_colour         : full-screen clear request (one-cycle strobe)
//   mem_addr, mem_data, mem_we  : frame memory write port (registered)
//   mem_ready                   : memory accepts when mem_we && mem_ready
//   busy                        : FIFO full or clear pending/running
//   clear_done                  : one-cycle pulse after the last clear write
//   overflow                    : sticky, a plot was dropped on a full FIFO
//   oob_count                   : saturating count of out-of-range plots
module plot_pixel_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int DEPTH  = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    input  logic        plot,
    input  logic        clear,
    input  logic [2:0]  clear_colour,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        busy,
    output logic        clear_done,
    output logic        overflow,
    output logic [7:0]  oob_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]  CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [7:0]   W8       = 8'(WIDTH);
    localparam logic [6:0]   H7       = 7'(HEIGHT);
    localparam logic [14:0]  LAST     = 15'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [17:0]   fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;

    logic [14:0] mem_addr_q, mem_addr_d;
    logic [2:0]  mem_data_q, mem_data_d;
    logic        mem_we_q, mem_we_d;
    logic        busy_q, busy_d;
    logic        clear_done_q, clear_done_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  oob_q, oob_d;
    logic        pend_q, pend_d;
    logic [2:0]  clr_col_q, clr_col_d;

    logic        in_range, full, clr_req, clr_go, accept;
    logic        push, pop, drop_full;
    logic [14:0] push_addr;
    logic [17:0] head;

    assign in_range = (x < W8) && (y < H7);
    assign full     = (count_q == CNT_FULL);
    // A clear is ignored while one is already running.
    assign clr_req  = clear && (state_q != S_CLEAR);
    assign clr_go   = pend_q || clr_req;
    assign accept   = mem_we_q && mem_ready;

    // The flush on a clear edge frees room for a same-edge plot.
    assign push      = plot && in_range && (!full || clr_req);
    assign drop_full = plot && in_range && full && !clr_req;

    // y*160 + x as shifts and adds
    assign push_addr = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    assign head      = fifo_q[rd_ptr_q];
    assign clr_col_d = clr_req ? clear_colour : clr_col_q;

    // State register plus all registered outputs and FIFO storage
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            oob_q        <= '0;
            pend_q       <= 1'b0;
            clr_col_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
            overflow_q   <= overflow_d;
            oob_q        <= oob_d;
            pend_q       <= pend_d;
            clr_col_q    <= clr_col_d;
            if (clr_req) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= push ? PW'(1) : '0;
                if (push) begin
                    fifo_q[0] <= {push_addr, colour};
                end
            end else begin
                if (push) begin
                    fifo_q[wr_ptr_q] <= {push_addr, colour};
                    wr_ptr_q         <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (clr_go) begin
                    state_d = S_CLEAR;
                end else if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (accept) begin
                    if (clr_go) begin
                        state_d = S_CLEAR;
                    end else if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CLEAR: begin
                if (accept && (mem_addr_q == LAST)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / bookkeeping next values
    always_comb begin
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        clear_done_d = (state_q == S_CLEAR) && (state_d == S_IDLE);

        if (state_d == S_CLEAR) begin
            mem_we_d = 1'b1;
            if (state_q != S_CLEAR) begin
                mem_addr_d = '0;
                mem_data_d = clr_col_d;
            end else if (accept) begin
                mem_addr_d = mem_addr_q + 15'd1;
            end
        end else if (pop) begin
            mem_we_d   = 1'b1;
            mem_addr_d = head[17:3];
            mem_data_d = head[2:0];
        end else if (state_d == S_IDLE) begin
            mem_we_d = 1'b0;
        end

        if (clr_req) begin
            count_d = push ? (PW+1)'(1) : '0;
        end else begin
            count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end

        pend_d     = clr_go && (state_d != S_CLEAR);
        busy_d     = (count_d == CNT_FULL) || (state_d == S_CLEAR) || pend_d;
        overflow_d = overflow_q || drop_full;

        oob_d = oob_q;
        if (plot && !in_range && (oob_q != 8'hFF)) begin
            oob_d = oob_q + 8'd1;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;
    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign overflow   = overflow_q;
    assign oob_count  = oob_q;

endmodule

// File: tb/tb_plot_pixel_sink.sv
// Directed testbench for plot_pixel_sink: plots, backpressure, range checks,
// clears and reset behaviour against hand-computed expected values.
module tb_plot_pixel_sink;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  x = '0;
    logic [6:0]  y = '0;
    logic [2:0]  colour = '0;
    logic        plot = 1'b0;
    logic        clear = 1'b0;
    logic [2:0]  clear_colour = '0;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic        busy;
    logic        clear_done;
    logic        overflow;
    logic [7:0]  oob_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [14:0] log_a[$];
    logic [2:0]  log_d[$];
    int          log_c[$];

    plot_pixel_sink dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .clear        (clear),
        .clear_colour (clear_colour),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .mem_ready    (mem_ready),
        .busy         (busy),
        .clear_done   (clear_done),
        .overflow     (overflow),
        .oob_count    (oob_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && mem_we && mem_ready) begin
            log_a.push_back(mem_addr);
            log_d.push_back(mem_data);
            log_c.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic log_clear();
        log_a.delete();
        log_d.delete();
        log_c.delete();
    endtask

    task automatic do_reset();
        plot = 1'b0;
        clear = 1'b0;
        mem_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        log_clear();
    endtask

    task automatic do_plot(input int px, input int py, input int pc);
        x = 8'(px);
        y = 7'(py);
        colour = 3'(pc);
        plot = 1'b1;
        tick();
        plot = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 15'd0 || mem_data !== 3'd0) begin
            failures++;
            $display("FAIL reset_port we=%b addr=%0d data=%0d want 0/0/0",
                     mem_we, mem_addr, mem_data);
        end
        checks++;
        if (busy !== 1'b0 || clear_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%b done=%b want 0/0",
                     busy, clear_done);
        end
        checks++;
        if (overflow !== 1'b0 || oob_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_err ovf=%b oob=%0d want 0/0",
                     overflow, oob_count);
        end
    endtask

    task automatic test_single_plot();
        do_reset();
        mem_ready = 1'b1;
        do_plot(10, 5, 3);
        checks++;
        if (mem_we !== 1'b0) begin
            failures++;
            $display("FAIL single_we_n got=%b want 0", mem_we);
        end
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd810 || mem_data !== 3'd3) begin
            failures++;
            $display("FAIL single_port we=%b addr=%0d data=%0d want 1/810/3",
                     mem_we, mem_addr, mem_data);
        end
        tick();
        checks++;
        if (mem_we !== 1'b0) begin
            failures++;
            $display("FAIL single_we_n2 got=%b want 0", mem_we);
        end
        repeat (3) tick();
        checks++;
        if (log_a.size() != 1) begin
            failures++;
            $display("FAIL single_count got=%0d want 1", log_a.size());
        end else if (log_a[0] !== 15'd810 || log_d[0] !== 3'd3) begin
            failures++;
            $display("FAIL single_write got=%0d/%0d want 810/3",
                     log_a[0], log_d[0]);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_plot(i, 0, i);
            if (i == 3) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_busy3 got=%b want 0", busy);
                end
            end
            if (i == 4) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_busy4 got=%b want 1", busy);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL bp_overflow got=%b want 1", overflow);
        end
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd0 || mem_data !== 3'd0) begin
            failures++;
            $display("FAIL bp_hold we=%b addr=%0d data=%0d want 1/0/0",
                     mem_we, mem_addr, mem_data);
        end
        mem_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (log_a.size() != 5) begin
            failures++;
            $display("FAIL bp_count got=%0d want 5", log_a.size());
        end else begin
            int bad = 0;
            for (int i = 0; i < 5; i++) begin
                if (log_a[i] !== 15'(i) || log_d[i] !== 3'(i)) bad++;
                if (i > 0 && log_c[i] != log_c[i-1] + 1) bad++;
            end
            if (bad != 0) begin
                failures++;
                $display("FAIL bp_order bad=%0d want 0 first=%0d last=%0d",
                         bad, log_a[0], log_a[4]);
            end
        end
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL bp_end busy=%b ovf=%b want 0/1", busy, overflow);
        end
    endtask

    task automatic test_oob();
        do_reset();
        mem_ready = 1'b1;
        do_plot(160, 0, 1);
        do_plot(0, 120, 1);
        do_plot(255, 127, 1);
        repeat (4) tick();
        checks++;
        if (oob_count !== 8'd3) begin
            failures++;
            $display("FAIL oob_three got=%0d want 3", oob_count);
        end
        checks++;
        if (log_a.size() != 0) begin
            failures++;
            $display("FAIL oob_writes got=%0d want 0", log_a.size());
        end
        for (int i = 0; i < 297; i++) begin
            do_plot(200, 3, 1);
        end
        tick();
        checks++;
        if (oob_count !== 8'd255) begin
            failures++;
            $display("FAIL oob_sat got=%0d want 255", oob_count);
        end
        checks++;
        if (overflow !== 1'b0 || log_a.size() != 0) begin
            failures++;
            $display("FAIL oob_side ovf=%b writes=%0d want 0/0",
                     overflow, log_a.size());
        end
    endtask

    task automatic wait_done(output int seen, output int at_size);
        seen = 0;
        at_size = -1;
        for (int k = 0; k < 25000; k++) begin
            tick();
            if (clear_done === 1'b1) begin
                seen = 1;
                at_size = log_a.size();
                break;
            end
        end
    endtask

    task automatic test_clear_with_plot();
        int seen, at_size, bad;
        do_reset();
        mem_ready = 1'b1;
        clear = 1'b1;
        clear_colour = 3'd7;
        x = 8'd159;
        y = 7'd119;
        colour = 3'd2;
        plot = 1'b1;
        tick();
        clear = 1'b0;
        plot = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL clr_busy busy=%b we=%b want 1/1", busy, mem_we);
        end
        wait_done(seen, at_size);
        checks++;
        if (seen != 1 || at_size != 19200) begin
            failures++;
            $display("FAIL clr_done seen=%0d writes=%0d want 1/19200",
                     seen, at_size);
        end
        repeat (5) tick();
        checks++;
        if (log_a.size() != 19201) begin
            failures++;
            $display("FAIL clr_total got=%0d want 19201", log_a.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 19200; i++) begin
                if (log_a[i] !== 15'(i) || log_d[i] !== 3'd7) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL clr_fill bad=%0d want 0", bad);
            end
            checks++;
            if (log_a[19200] !== 15'd19199 || log_d[19200] !== 3'd2) begin
                failures++;
                $display("FAIL clr_plot got=%0d/%0d want 19199/2",
                         log_a[19200], log_d[19200]);
            end
        end
    endtask

    task automatic test_clear_during_write();
        int seen, at_size;
        do_reset();
        mem_ready = 1'b0;
        do_plot(100, 0, 1);
        do_plot(101, 0, 1);
        do_plot(102, 0, 1);
        tick();
        clear = 1'b1;
        clear_colour = 3'd5;
        tick();
        clear = 1'b0;
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd100 || busy !== 1'b1) begin
            failures++;
            $display("FAIL cdw_hold we=%b addr=%0d busy=%b want 1/100/1",
                     mem_we, mem_addr, busy);
        end
        mem_ready = 1'b1;
        wait_done(seen, at_size);
        checks++;
        if (seen != 1 || at_size != 19201) begin
            failures++;
            $display("FAIL cdw_done seen=%0d writes=%0d want 1/19201",
                     seen, at_size);
        end
        repeat (5) tick();
        checks++;
        if (log_a.size() != 19201) begin
            failures++;
            $display("FAIL cdw_total got=%0d want 19201", log_a.size());
        end else begin
            checks++;
            if (log_a[0] !== 15'd100 || log_d[0] !== 3'd1 ||
                log_a[1] !== 15'd0 || log_d[1] !== 3'd5 ||
                log_a[19200] !== 15'd19199) begin
                failures++;
                $display("FAIL cdw_seq got=%0d/%0d,%0d/%0d,%0d want 100/1,0/5,19199",
                         log_a[0], log_d[0], log_a[1], log_d[1], log_a[19200]);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int hit = 0;
        do_reset();
        mem_ready = 1'b1;
        clear = 1'b1;
        clear_colour = 3'd3;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            if (mem_addr == 15'd5000) begin
                hit = 1;
                break;
            end
            tick();
        end
        checks++;
        if (hit != 1) begin
            failures++;
            $display("FAIL rmc_reach got=%0d want 5000", mem_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 15'd0 || mem_data !== 3'd0 ||
            busy !== 1'b0 || clear_done !== 1'b0) begin
            failures++;
            $display("FAIL rmc_async we=%b addr=%0d data=%0d busy=%b want 0/0/0/0",
                     mem_we, mem_addr, mem_data, busy);
        end
        tick();
        reset = 1'b0;
        log_clear();
        repeat (50) tick();
        checks++;
        if (log_a.size() != 0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL rmc_quiet writes=%0d we=%b want 0/0",
                     log_a.size(), mem_we);
        end
    endtask

    initial begin
        test_reset();
        test_single_plot();
        test_backpressure();
        test_oob();
        test_clear_with_plot();
        test_clear_during_write();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/plot_pixel_sink.md
# plot_pixel_sink

Receiving end of the pixel-plot interface driven by the shape-drawing datapaths: accepts `x`/`y`/`colour`/`plot` strobes, buffers them in a 4-entry FIFO, and writes each pixel into a 160x120, 3-bit-per-pixel frame memory through a ready/valid write port. It also executes full-screen clears. It sits between the drawing datapaths and the frame-buffer RAM, replacing the direct adapter hookup.

## Interface
- `WIDTH`, 160: screen width in pixels; `x` must be < `WIDTH`
- `HEIGHT`, 120: screen height in pixels; `y` must be < `HEIGHT`
- `DEPTH`, 4: FIFO entries (power of two)

- `CLOCK_50` in 1: the single clock; all state is on its rising edge
- `reset` in 1: asynchronous, active-high; forces every register to its reset value
- `x` in 8: pixel column
- `y` in 7: pixel row
- `colour` in 3: pixel colour
- `plot` in 1: one-cycle request; `x`/`y`/`colour` are sampled on the same edge
- `clear` in 1: one-cycle request to fill the whole screen with `clear_colour`
- `clear_colour` in 3: sampled on the `clear` edge
- `mem_addr` out 15: address = y*160 + x, range 0..19199
- `mem_data` out 3: colour to write
- `mem_we` out 1: write valid
- `mem_ready` in 1: memory accepts the write on an edge where `mem_we && mem_ready`
- `busy` out 1: high when the FIFO is full or a clear is running
- `clear_done` out 1: one-cycle pulse after the last clear write is accepted
- `overflow` out 1: sticky; set when a `plot` is dropped because the FIFO is full
- `oob_count` out 8: saturating count of `plot` requests dropped as out of range

## Operation
- Push rules, evaluated on each `plot` edge:
  - If `x >= 160` or `y >= 120`, drop the request and increment `oob_count`, saturating at 255.
  - Else if the registered FIFO count equals `DEPTH`, drop the request and set `overflow`. This applies even if a pop happens on the same edge.
  - Else push {addr, colour}. The address is computed at push time as (y<<7)+(y<<5)+x.
- FSM states:
  - **IDLE**: `mem_we` is 0. On `clear` go to CLEAR. Otherwise, if the FIFO is non-empty, load the head entry onto `mem_addr`/`mem_data`, pop it, and go to WRITE.
  - **WRITE**: `mem_we` is 1, and `mem_addr`/`mem_data` stay stable until `mem_ready`. On accept:
    - `clear` pending: go to CLEAR.
    - FIFO non-empty: load and pop the next entry, stay in WRITE (back-to-back, no bubble).
    - Otherwise go to IDLE.
  - **CLEAR**: `mem_we` is 1 and `mem_data` = latched `clear_colour`. `mem_addr` starts at 0 and increments on each accept. On the accept at 19199, pulse `clear_done` next cycle and return to IDLE.
- Clear semantics:
  - On the `clear` edge the FIFO is flushed and `clear_pending` is set.
  - A write already presented in WRITE completes before CLEAR begins. It is not aborted.
  - `plot` on the same edge as `clear`, or any `plot` during CLEAR, is pushed after the flush and drawn after the clear completes.
  - `clear` while already in CLEAR is ignored; the address does not restart.
- Write ordering to memory is strictly FIFO order.
- `busy` = (count == `DEPTH`) | (state == CLEAR) | `clear_pending`.

## Timing
- Reset values:
  - FSM in IDLE, FIFO empty.
  - `mem_we`=0, `mem_addr`=0, `mem_data`=0.
  - `busy`=0, `clear_done`=0, `overflow`=0, `oob_count`=0.
- Latency: a `plot` at edge N into an empty FIFO with the FSM in IDLE gives `mem_we`=1 after edge N+1 and is accepted at the first edge ≥ N+2 with `mem_ready`=1.
- Sustained throughput with `mem_ready` held at 1 is one pixel per clock.
- A full clear with `mem_ready`=1 takes 19200 accept cycles, plus 1 entry cycle.
- All outputs are registered; no combinational path from `mem_ready` to `mem_addr`/`mem_data`.
- Asserting `reset` mid-write or mid-clear drops everything immediately. The pending memory write is abandoned, because `mem_we` falls asynchronously.

## Test plan
- **Single plot**: reset, then `plot` x=10 y=5 colour=3 with `mem_ready`=1 → exactly one write addr=810 data=3, `mem_we` high for one cycle starting at N+1.
- **Backpressure and overflow**: hold `mem_ready`=0 and issue 6 plots, (0,0) .. (5,0).
  - Required response: `busy` rises once 4 entries are queued (with the FSM in IDLE this is after the 4th plot's edge); `overflow`=1.
  - After releasing `mem_ready`, the writes are addrs 0,1,2,3,4, in order, with no gaps. The first plot is not in the FIFO; it is held on the port.
- **Out of range**: plots at (160,0), (0,120), and (255,127) → no writes, `oob_count`=3. After 300 such plots, `oob_count`=255.
- **Clear with plot**: `clear` colour=7 and `plot` (159,119) colour=2 on the same edge → 19200 writes of 7 to addrs 0..19199, then the `clear_done` pulse, then addr 19199 data 2.
- **Clear during write**: FIFO holds 3 entries and the head is stalled by `mem_ready`=0 when `clear` arrives. Release `mem_ready` → the head write completes, the 2 queued entries are discarded, and the clear runs from address 0.
- **Reset mid-clear**: assert `reset` at address 5000 → all outputs take their reset values immediately; after release, no writes occur until a new request.
